// File: rtl/alu_share_pkg.sv
// Shared types for the ALU-sharing arbiter: opcode and FSM state encodings,
// plus the result-width helper used by the core and the arbiter.
package alu_share_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Results are twice the operand width so a full product always fits.
  function automatic int res_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational add/sub/mul/div datapath shared by all requesters.
// Define ALU_DIV_EN to build the divider; otherwise op=DIV returns data=0, err=1.
module alu_core
  import alu_share_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  alu_op_e        op_i,
  output logic [2*W-1:0] data_o,
  output logic           err_o
);

  localparam int RW = res_w(W);

  logic [W:0]    sum_w;
  logic [W:0]    diff_w;
  logic [RW-1:0] prod_w;

  assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
  // One extra bit keeps the true sign of a-b for the sign extension below.
  assign diff_w = {1'b0, a_i} - {1'b0, b_i};
  assign prod_w = RW'(a_i) * RW'(b_i);

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    case (op_i)
      OP_ADD: data_o = RW'(sum_w);
      OP_SUB: data_o = {{(RW-W-1){diff_w[W]}}, diff_w};
      OP_MUL: data_o = prod_w;
      OP_DIV: begin
`ifdef ALU_DIV_EN
        if (b_i == '0) begin
          data_o = '1;
          err_o  = 1'b1;
        end else begin
          data_o = RW'(a_i / b_i);
        end
`else
        data_o = '0;
        err_o  = 1'b1;
`endif
      end
      default: begin
        data_o = '0;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one alu_core among NREQ requesters; one op in flight,
// sequenced IDLE -> EXEC -> RESP. Divider presence follows the ALU_DIV_EN macro.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int W    = 8,
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*2-1:0] req_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [2*W-1:0]    resp_data,
  output logic              resp_err
);

  localparam int           RW     = res_w(W);
  localparam logic [IDW:0] NREQ_X = (IDW+1)'(NREQ);

  logic [W-1:0] a_arr  [NREQ];
  logic [W-1:0] b_arr  [NREQ];
  logic [1:0]   op_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi]  = req_a[gi*W +: W];
      assign b_arr[gi]  = req_b[gi*W +: W];
      assign op_arr[gi] = req_op[gi*2 +: 2];
    end
  endgenerate

  state_e        state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  alu_op_e       op_q;
  logic [IDW-1:0] id_q;
  logic          resp_valid_q;
  logic [IDW-1:0] resp_id_q;
  logic [RW-1:0] resp_data_q;
  logic          resp_err_q;

  logic [NREQ-1:0] valid_rot;
  logic            grant_found;
  logic [IDW:0]    grant_off;
  logic [IDW:0]    grant_sum;
  logic [IDW:0]    next_sum;
  logic [IDW-1:0]  grant_idx;
  logic            accept;

  logic [RW-1:0] alu_data;
  logic          alu_err;

  // Rotate the valid vector so bit 0 is the requester the pointer favours.
  assign valid_rot = NREQ'({req_valid, req_valid} >> ptr_q);

  always_comb begin
    grant_found = 1'b0;
    grant_off   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        grant_found = 1'b1;
        grant_off   = (IDW+1)'(k);
      end
    end
  end

  always_comb begin
    grant_sum = {1'b0, ptr_q} + grant_off;
    if (grant_sum >= NREQ_X) begin
      grant_sum = grant_sum - NREQ_X;
    end
    grant_idx = IDW'(grant_sum);

    next_sum = {1'b0, grant_idx} + (IDW+1)'(1);
    if (next_sum >= NREQ_X) begin
      next_sum = '0;
    end
    ptr_d = IDW'(next_sum);
  end

  assign accept = (state_q == ST_IDLE) && grant_found;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  alu_core #(
    .W (W)
  ) u_alu_core (
    .a_i    (a_q),
    .b_i    (b_q),
    .op_i   (op_q),
    .data_o (alu_data),
    .err_o  (alu_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q     <= a_arr[grant_idx];
            b_q     <= b_arr[grant_idx];
            op_q    <= alu_op_e'(op_arr[grant_idx]);
            id_q    <= grant_idx;
            ptr_q   <= ptr_d;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_data_q  <= alu_data;
          resp_err_q   <= alu_err;
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          // Response fields stay put until the consumer takes them.
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter (W=8, NREQ=2): directed steps then
// random traffic, checked against an arithmetic/round-robin reference model.
module tb_alu_share_arbiter;

  localparam int W    = 8;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*2-1:0] req_op;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [2*W-1:0]    resp_data;
  logic              resp_err;

  alu_share_arbiter #(
    .W    (W),
    .NREQ (NREQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int data;
    bit err;
  } exp_t;

  exp_t q[$];
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   total     = 0;
  bit   inflight  = 0;
  int   age       = 0;
  int   ptr       = 0;
  bit   after_rst = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Plain integer arithmetic; results live in 16 bits (2*W).
  function automatic void ref_alu(input int a, input int b, input int op,
                                  output int d, output bit e);
    e = 0;
    d = 0;
    case (op)
      0: d = a + b;
      1: d = (a - b) & 32'h0000_FFFF;
      2: d = a * b;
      default: begin
`ifdef ALU_DIV_EN
        if (b == 0) begin
          d = 32'h0000_FFFF;
          e = 1;
        end else begin
          d = a / b;
        end
`else
        d = 0;
        e = 1;
`endif
      end
    endcase
  endfunction

  // First valid requester at or after the round-robin pointer, wrapping.
  function automatic int pick(input logic [1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (v[i[0]]) return i;
    end
    return -1;
  endfunction

  task automatic tick(input logic [1:0] v,
                      input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] o0,
                      input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] o1,
                      input logic rr, input logic r);
    int   w;
    bit   exp_rv;
    logic [1:0] exp_ready;
    exp_t e;
    @(negedge clk);
    req_valid  = v;
    req_a      = {a1, a0};
    req_b      = {b1, b0};
    req_op     = {o1, o0};
    resp_ready = rr;
    rst        = r;
    #1;
    if (after_rst) begin
      chk("rst_resp_data", 32'(resp_data), 32'd0);
      chk("rst_resp_id",   32'(resp_id),   32'd0);
      chk("rst_resp_err",  32'(resp_err),  32'd0);
    end
    exp_rv = inflight && (age >= 2);
    chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
    if (exp_rv && q.size() > 0) begin
      chk("resp_data", 32'(resp_data), 32'(q[0].data));
      chk("resp_id",   32'(resp_id),   32'(q[0].id));
      chk("resp_err",  32'(resp_err),  32'(q[0].err));
    end
    w = inflight ? -1 : pick(v, ptr);
    exp_ready = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));

    if (r) begin
      inflight  = 0;
      age       = 0;
      ptr       = 0;
      after_rst = 1;
      q.delete();
    end else begin
      after_rst = 0;
      if (exp_rv && rr) begin
        inflight = 0;
        void'(q.pop_front());
      end else if (inflight) begin
        age++;
      end
      if (w >= 0) begin
        e.id = w;
        if (w == 0) ref_alu(int'(a0), int'(b0), int'(o0), e.data, e.err);
        else        ref_alu(int'(a1), int'(b1), int'(o1), e.data, e.err);
        q.push_back(e);
        inflight = 1;
        age      = 1;
        ptr      = (w + 1) % NREQ;
      end
    end
  endtask

  // Accept, execute, respond (resp_ready=1) for one requester in three ticks.
  task automatic single(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op);
    if (idx == 0) tick(2'b01, a, b, op, 8'd0, 8'd0, 2'd0, 1'b1, 1'b0);
    else          tick(2'b10, 8'd0, 8'd0, 2'd0, a, b, op, 1'b1, 1'b0);
    tick(2'b00, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0, 2'd0, 1'b1, 1'b0);
    tick(2'b00, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0, 2'd0, 1'b1, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b0;

    repeat (2) tick(2'b00, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b1);
    tick(2'b00, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0);

    // Both requesters valid: ADD 3+4 on 0, SUB 3-4 on 1; grants must alternate.
    repeat (12) tick(2'b11, 8'd3, 8'd4, 2'd0, 8'd3, 8'd4, 2'd1, 1'b1, 1'b0);
    tick(2'b00, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0, 2'd0, 1'b1, 1'b0);

    single(0, 8'd10, 8'd5, 2'd2);
    chk("mul_10x5", 32'(resp_data), 32'd50);
    chk("mul_10x5_id", 32'(resp_id), 32'd0);

    single(0, 8'd9, 8'd0, 2'd3);
`ifdef ALU_DIV_EN
    chk("div_by_zero_data", 32'(resp_data), 32'h0000_FFFF);
`else
    chk("div_by_zero_data", 32'(resp_data), 32'd0);
`endif
    chk("div_by_zero_err", 32'(resp_err), 32'd1);

    single(1, 8'd9, 8'd3, 2'd3);
`ifdef ALU_DIV_EN
    chk("div_9_3_data", 32'(resp_data), 32'd3);
    chk("div_9_3_err",  32'(resp_err),  32'd0);
`else
    chk("div_9_3_data", 32'(resp_data), 32'd0);
    chk("div_9_3_err",  32'(resp_err),  32'd1);
`endif

    // Backpressure on a requester-1 MUL: five stalled cycles with both valid.
    tick(2'b10, 8'd0, 8'd0, 2'd0, 8'd7, 8'd6, 2'd2, 1'b0, 1'b0);
    tick(2'b00, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0);
    repeat (5) tick(2'b11, 8'd1, 8'd1, 2'd0, 8'd2, 8'd2, 2'd0, 1'b0, 1'b0);
    chk("bp_resp_id",   32'(resp_id),   32'd1);
    chk("bp_resp_data", 32'(resp_data), 32'd42);
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    tick(2'b00, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0, 2'd0, 1'b1, 1'b0);
    tick(2'b11, 8'd1, 8'd1, 2'd0, 8'd2, 8'd2, 2'd0, 1'b1, 1'b0);
    chk("bp_next_grant", 32'(req_ready), 32'd1);
    repeat (2) tick(2'b00, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0, 2'd0, 1'b1, 1'b0);

    // Reset during EXEC: no response, pointer back to requester 0.
    tick(2'b01, 8'd1, 8'd2, 2'd0, 8'd0, 8'd0, 2'd0, 1'b1, 1'b0);
    tick(2'b00, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0, 2'd0, 1'b1, 1'b1);
    tick(2'b11, 8'd5, 8'd6, 2'd0, 8'd7, 8'd8, 2'd0, 1'b1, 1'b0);
    chk("rst_mid_grant", 32'(req_ready), 32'd1);
    repeat (2) tick(2'b00, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0, 2'd0, 1'b1, 1'b0);

    single(0, 8'd255, 8'd255, 2'd2);
    chk("mul_255x255", 32'(resp_data), 32'd65025);
    single(1, 8'd255, 8'd1, 2'd0);
    chk("add_255_1", 32'(resp_data), 32'd256);
    single(0, 8'd0, 8'd1, 2'd1);
    chk("sub_0_1", 32'(resp_data), 32'h0000_FFFF);

    for (int n = 0; n < 600; n++) begin
      tick(2'($urandom), 8'($urandom), 8'($urandom_range(0, 3)), 2'($urandom),
           8'($urandom), 8'($urandom), 2'($urandom),
           logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 79) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
